// File: rtl/xgmii2gmii_tx.sv
// Purpose : drains 72-bit XGMII words from a FWFT FIFO and serializes them lane-by-lane onto GMII TX.
// Latency : word popped at cycle t -> its lane 0 result on the GMII pins at t+2.
// Backpressure: pops only when the word buffer is free or its last lane is taken; holds the word during the IPG.
// Ports:
//   gmii_clk, sys_rst_n        : 125 MHz clock, async active-low reset
//   xgmii_din/xgmii_empty      : FIFO head {ctrl[7:0], data[63:0]} and its empty flag
//   xgmii_rd_en                : combinational pop of the FIFO head
//   gmii_tx_en/_er/gmii_txd    : registered GMII transmit pins
//   frame_done/frame_err       : registered one-cycle status pulses
module xgmii2gmii_tx #(
   parameter int IPG_BYTES = 12
) (
   input  logic        gmii_clk,
   input  logic        sys_rst_n,
   input  logic [71:0] xgmii_din,
   input  logic        xgmii_empty,
   output logic        xgmii_rd_en,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic [7:0]  gmii_txd,
   output logic        frame_done,
   output logic        frame_err
);

   localparam int            CW       = (IPG_BYTES > 1) ? $clog2(IPG_BYTES) : 1;
   localparam logic [CW-1:0] IPG_LOAD = CW'(IPG_BYTES - 1);

   localparam logic [7:0] C_START = 8'hFB;
   localparam logic [7:0] C_TERM  = 8'hFD;
   localparam logic [7:0] C_ERROR = 8'hFE;
   localparam logic [7:0] C_IDLE  = 8'h07;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ABORT, S_IPG} state_t;

   state_t          r_state;
   logic [71:0]     r_w;
   logic            r_wvalid;
   logic [2:0]      r_idx;
   logic [CW-1:0]   r_ipg_cnt;

   logic            w_lane_take;
   logic [7:0]      w_ctrl;
   logic            w_c;
   logic [63:0]     w_shift;
   logic [7:0]      w_d;

   // The IPG state freezes the lane pointer so the held /S/ is replayed afterwards.
   assign w_lane_take = r_wvalid && (r_state != S_IPG);
   assign w_ctrl      = r_w[71:64];
   assign w_c         = w_ctrl[r_idx];
   assign w_shift     = r_w[63:0] >> {r_idx, 3'b000};
   assign w_d         = w_shift[7:0];

   assign xgmii_rd_en = !xgmii_empty && (!r_wvalid || (w_lane_take && (r_idx == 3'd7)));

   // Word buffer: one XGMII word and the lane currently presented to the FSM.
   always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_w      <= '0;
         r_wvalid <= 1'b0;
         r_idx    <= 3'd0;
      end else if (xgmii_rd_en) begin
         r_w      <= xgmii_din;
         r_wvalid <= 1'b1;
         r_idx    <= 3'd0;
      end else if (w_lane_take) begin
         r_idx <= r_idx + 3'd1;
         if (r_idx == 3'd7)
            r_wvalid <= 1'b0;
      end
   end

   // Framing FSM with registered GMII outputs; one lane per cycle.
   always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= S_IDLE;
         r_ipg_cnt  <= '0;
         gmii_tx_en <= 1'b0;
         gmii_tx_er <= 1'b0;
         gmii_txd   <= 8'h00;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               gmii_tx_en <= 1'b0;
               gmii_tx_er <= 1'b0;
               gmii_txd   <= 8'h00;
               if (r_wvalid && w_c && (w_d == C_START)) begin
                  gmii_tx_en <= 1'b1;
                  gmii_txd   <= 8'h55;
                  r_state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (!r_wvalid) begin
                  // Underrun: poison the frame on the wire and wait for its end.
                  gmii_tx_en <= 1'b1;
                  gmii_tx_er <= 1'b1;
                  gmii_txd   <= 8'h00;
                  frame_err  <= 1'b1;
                  r_state    <= S_ABORT;
               end else if (!w_c) begin
                  gmii_tx_en <= 1'b1;
                  gmii_tx_er <= 1'b0;
                  gmii_txd   <= w_d;
               end else if (w_d == C_TERM) begin
                  gmii_tx_en <= 1'b0;
                  gmii_tx_er <= 1'b0;
                  gmii_txd   <= 8'h00;
                  frame_done <= 1'b1;
                  r_ipg_cnt  <= IPG_LOAD;
                  r_state    <= (IPG_BYTES == 1) ? S_IDLE : S_IPG;
               end else if (w_d == C_ERROR) begin
                  gmii_tx_en <= 1'b1;
                  gmii_tx_er <= 1'b1;
                  gmii_txd   <= w_d;
                  frame_err  <= 1'b1;
               end else begin
                  // Any other control byte (including a second /S/) kills the frame.
                  gmii_tx_en <= 1'b1;
                  gmii_tx_er <= 1'b1;
                  gmii_txd   <= w_d;
                  frame_err  <= 1'b1;
                  r_state    <= S_ABORT;
               end
            end
            S_ABORT: begin
               gmii_tx_en <= 1'b0;
               gmii_tx_er <= 1'b0;
               gmii_txd   <= 8'h00;
               if (r_wvalid && w_c && ((w_d == C_TERM) || (w_d == C_IDLE))) begin
                  r_ipg_cnt <= IPG_LOAD;
                  r_state   <= S_IPG;
               end
            end
            S_IPG: begin
               gmii_tx_en <= 1'b0;
               gmii_tx_er <= 1'b0;
               gmii_txd   <= 8'h00;
               if (r_ipg_cnt == '0)
                  r_state <= S_IDLE;
               else
                  r_ipg_cnt <= r_ipg_cnt - CW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xgmii2gmii_tx.sv
// Purpose : self-checking bench for xgmii2gmii_tx: cycle table, directed corner sequences, random frames.
// Latency : expectations in the cycle table assume lane 0 of a popped word appears two cycles later.
// Backpressure: a queue-based FWFT FIFO model feeds the DUT and honours xgmii_rd_en.
module tb_xgmii2gmii_tx;

   localparam int IPG = 12;

   logic        gmii_clk    = 1'b0;
   logic        sys_rst_n   = 1'b1;
   logic [71:0] xgmii_din   = '0;
   logic        xgmii_empty = 1'b1;
   logic        xgmii_rd_en;
   logic        gmii_tx_en;
   logic        gmii_tx_er;
   logic [7:0]  gmii_txd;
   logic        frame_done;
   logic        frame_err;

   xgmii2gmii_tx #(.IPG_BYTES(IPG)) dut (
      .gmii_clk    (gmii_clk),
      .sys_rst_n   (sys_rst_n),
      .xgmii_din   (xgmii_din),
      .xgmii_empty (xgmii_empty),
      .xgmii_rd_en (xgmii_rd_en),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_tx_er  (gmii_tx_er),
      .gmii_txd    (gmii_txd),
      .frame_done  (frame_done),
      .frame_err   (frame_err)
   );

   always #4 gmii_clk = ~gmii_clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        empty;
      logic [71:0] din;
      logic        rd;
      logic        en;
      logic        er;
      logic [7:0]  txd;
      logic        done;
      logic        err;
   } vec_t;
   vec_t tbl[$];

   // Lane stream model: {ctrl, data} lanes, packed into FIFO words on flush.
   logic [8:0]  lanes[$];
   logic [71:0] wq[$];
   int          sq[$];
   bit          lf_in_frame = 1'b0;
   bit          tbl_mode    = 1'b1;

   // Expected and captured GMII streams: {marker, er, txd}; marker 10'h200 ends a burst.
   logic [9:0]  cap[$];
   logic [9:0]  exp_s[$];
   int          exp_done = 0, exp_err = 0, dut_done = 0, dut_err = 0;
   bit          prev_en = 1'b0;
   int          gap = 1000;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // FWFT FIFO model; a word may be held back a few cycles after reaching the head.
   always @(negedge gmii_clk) begin
      if (!tbl_mode) begin
         if (wq.size() == 0) begin
            xgmii_empty = 1'b1;
            xgmii_din   = '0;
         end else if (sq[0] > 0) begin
            xgmii_empty = 1'b1;
            sq[0]       = sq[0] - 1;
         end else begin
            xgmii_empty = 1'b0;
            xgmii_din   = wq[0];
         end
      end
   end

   always @(posedge gmii_clk) begin
      if (!tbl_mode && xgmii_rd_en && (wq.size() > 0)) begin
         void'(wq.pop_front());
         void'(sq.pop_front());
      end
   end

   // Monitor: burst capture, status pulse counts, gap and done alignment checks.
   always @(posedge gmii_clk) begin
      #1;
      if (!sys_rst_n) begin
         prev_en = 1'b0;
         gap     = 1000;
      end else begin
         if (gmii_tx_en) begin
            if (!prev_en) begin
               checks++;
               if (gap < IPG) begin
                  errors++;
                  $display("FAIL ipg_gap: got %0d idle cycles, want >= %0d", gap, IPG);
               end
            end
            cap.push_back({1'b0, gmii_tx_er, gmii_txd});
            gap = 0;
         end else begin
            if (prev_en) cap.push_back(10'h200);
            gap++;
         end
         if (frame_done) begin
            dut_done++;
            checks++;
            if (!(prev_en && !gmii_tx_en)) begin
               errors++;
               $display("FAIL done_align: frame_done without tx_en fall (en %b prev %b)", gmii_tx_en, prev_en);
            end
         end
         if (frame_err) dut_err++;
         prev_en = gmii_tx_en;
      end
   end

   task automatic push_row(input logic e, input logic [71:0] d, input logic rd, input logic en,
                           input logic er, input logic [7:0] txd, input logic dn, input logic fe);
      vec_t v;
      v.empty = e; v.din = d; v.rd = rd; v.en = en; v.er = er; v.txd = txd; v.done = dn; v.err = fe;
      tbl.push_back(v);
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) lanes.push_back({1'b1, 8'h07});
   endtask

   task automatic add_frame(input int plen, input int fe_pct, input int fe_at);
      logic [7:0] d;
      lanes.push_back({1'b1, 8'hFB});
      for (int i = 0; i < 6; i++) lanes.push_back({1'b0, 8'h55});
      lanes.push_back({1'b0, 8'hD5});
      for (int i = 0; i < 7; i++) exp_s.push_back({2'b00, 8'h55});
      exp_s.push_back({2'b00, 8'hD5});
      for (int p = 0; p < plen; p++) begin
         if ((p == fe_at) || ($urandom_range(99) < fe_pct)) begin
            lanes.push_back({1'b1, 8'hFE});
            exp_s.push_back({2'b01, 8'hFE});
            exp_err++;
         end else begin
            d = 8'($urandom);
            lanes.push_back({1'b0, d});
            exp_s.push_back({2'b00, d});
         end
      end
      lanes.push_back({1'b1, 8'hFD});
      exp_s.push_back(10'h200);
      exp_done++;
   endtask

   task automatic flush(input bit allow_stall);
      logic [71:0] word;
      logic [8:0]  l;
      int          st;
      while ((lanes.size() % 8) != 0) lanes.push_back({1'b1, 8'h07});
      while (lanes.size() > 0) begin
         st = 0;
         if (allow_stall && !lf_in_frame && ($urandom_range(3) == 0)) st = $urandom_range(5, 1);
         word = '0;
         for (int i = 0; i < 8; i++) begin
            l = lanes.pop_front();
            word[64+i]    = l[8];
            word[8*i +: 8] = l[7:0];
            if (l[8] && (l[7:0] == 8'hFB)) lf_in_frame = 1'b1;
            else if (l[8] && (l[7:0] == 8'hFD)) lf_in_frame = 1'b0;
         end
         wq.push_back(word);
         sq.push_back(st);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((wq.size() != 0) && (n < 20000)) begin
         @(posedge gmii_clk);
         n++;
      end
      checks++;
      if (wq.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words left, want 0", name, wq.size());
      end
      repeat (60) @(posedge gmii_clk);
      #2;
   endtask

   task automatic clear_sb();
      cap.delete();
      exp_s.delete();
      exp_done = 0; exp_err = 0; dut_done = 0; dut_err = 0;
   endtask

   task automatic compare(input string name);
      int bad;
      bad = -1;
      checks++;
      if (cap.size() != exp_s.size()) begin
         errors++;
         $display("FAIL %s_len: got %0d stream entries, want %0d", name, cap.size(), exp_s.size());
      end else begin
         for (int i = 0; i < cap.size(); i++)
            if ((cap[i] !== exp_s[i]) && (bad < 0)) bad = i;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL %s_data: entry %0d got %h want %h", name, bad, cap[bad], exp_s[bad]);
         end
      end
      chk({name, "_done"}, 16'(dut_done), 16'(exp_done));
      chk({name, "_err"},  16'(dut_err),  16'(exp_err));
      clear_sb();
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      wq.delete();
      sq.delete();
      lanes.delete();
      lf_in_frame = 1'b0;
      repeat (3) @(posedge gmii_clk);
      @(negedge gmii_clk);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [71:0] wa, wb;
      int          n;
      wa = {8'h01, 64'hD5555555_555555FB};
      wb = {8'hFE, 64'h07070707_07FDFE11};

      // Reset state
      #2 sys_rst_n = 1'b0;
      repeat (2) @(posedge gmii_clk);
      #1;
      chk("reset_state", {4'h0, xgmii_rd_en, gmii_tx_en, gmii_tx_er, frame_done, gmii_txd}, 16'h0000);
      @(negedge gmii_clk);
      sys_rst_n = 1'b1;

      // Cycle-accurate table: short frame with /E/, then IPG, then a held /S/.
      push_row(0, wa, 1, 0, 0, 8'h00, 0, 0);
      for (int i = 1; i < 8; i++) push_row(0, wb, 0, 1, 0, 8'h55, 0, 0);
      push_row(0, wb, 1, 1, 0, 8'hD5, 0, 0);
      push_row(0, wa, 0, 1, 0, 8'h11, 0, 0);
      push_row(0, wa, 0, 1, 1, 8'hFE, 0, 1);
      push_row(0, wa, 0, 0, 0, 8'h00, 1, 0);
      for (int i = 12; i < 28; i++) push_row(0, wa, 0, 0, 0, 8'h00, 0, 0);
      push_row(0, wa, 1, 0, 0, 8'h00, 0, 0);
      push_row(1, '0, 0, 1, 0, 8'h55, 0, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge gmii_clk);
         xgmii_empty = tbl[i].empty;
         xgmii_din   = tbl[i].din;
         #1;
         chk($sformatf("tbl_rd[%0d]", i), 16'(xgmii_rd_en), 16'(tbl[i].rd));
         @(posedge gmii_clk);
         #1;
         chk($sformatf("tbl_out[%0d]", i),
             {4'h0, gmii_tx_en, gmii_tx_er, gmii_txd, frame_done, frame_err},
             {4'h0, tbl[i].en, tbl[i].er, tbl[i].txd, tbl[i].done, tbl[i].err});
      end

      tbl_mode    = 1'b0;
      xgmii_empty = 1'b1;
      do_reset();
      clear_sb();

      // Long frame, /S/ on lane 2
      add_idle(2);
      add_frame(68, 0, -1);
      flush(1'b0);
      drain("long");
      compare("long");

      // /S/ on lane 4, then /T/ on lane 3 immediately followed by /S/ on lane 4
      add_idle(4);
      add_frame(7, 0, -1);
      add_frame(5, 0, -1);
      flush(1'b0);
      drain("b2b");
      compare("b2b");

      // /E/ replacing one data lane
      add_frame(9, 0, 3);
      flush(1'b0);
      drain("fe");
      compare("fe");

      // Underrun: preamble word, FIFO runs dry, rest of the frame arrives late
      lanes.push_back({1'b1, 8'hFB});
      for (int i = 0; i < 6; i++) lanes.push_back({1'b0, 8'h55});
      lanes.push_back({1'b0, 8'hD5});
      for (int i = 0; i < 7; i++) exp_s.push_back({2'b00, 8'h55});
      exp_s.push_back({2'b00, 8'hD5});
      exp_s.push_back({2'b01, 8'h00});
      exp_s.push_back(10'h200);
      exp_err++;
      flush(1'b0);
      drain("urun_a");
      for (int i = 0; i < 4; i++) lanes.push_back({1'b0, 8'(8'hA0 + i)});
      lanes.push_back({1'b1, 8'hFD});
      add_idle(3);
      add_frame(6, 0, -1);
      flush(1'b0);
      drain("urun_b");
      compare("urun");

      // Asynchronous reset in mid-frame
      add_frame(40, 0, -1);
      flush(1'b0);
      n = 0;
      do begin
         @(posedge gmii_clk);
         #1;
         n++;
      end while (!gmii_tx_en && (n < 200));
      chk("rst_pre_en", 16'(gmii_tx_en), 16'h0001);
      repeat (10) @(posedge gmii_clk);
      #3;
      sys_rst_n = 1'b0;
      wq.delete();
      sq.delete();
      #1;
      chk("rst_async", {4'h0, gmii_tx_en, gmii_tx_er, gmii_txd, frame_done, frame_err}, 16'h0000);
      repeat (2) @(posedge gmii_clk);
      @(negedge gmii_clk);
      sys_rst_n   = 1'b1;
      lf_in_frame = 1'b0;
      clear_sb();
      for (int i = 0; i < 10; i++) lanes.push_back({1'b0, 8'($urandom)});
      lanes.push_back({1'b1, 8'hFD});
      add_idle(5);
      add_frame(4, 0, -1);
      flush(1'b0);
      drain("rst");
      compare("rst");

      // Random frames with random gaps, /E/ lanes and FIFO stalls between frames
      for (int f = 0; f < 30; f++) begin
         add_idle($urandom_range(20));
         add_frame($urandom_range(40, 1), 10, -1);
      end
      flush(1'b1);
      drain("rand");
      compare("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
